// File: rtl/puf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : puf_pkg
//  Description : Shared types and constants for the XOR arbiter PUF
//                evaluation controller.
//  Revision    : 1.0  initial release
// ============================================================================
package puf_pkg;

    // Default challenge width of the attached xor_top instance.
    localparam int PUF_N_DEFAULT  = 128;

    // Width of the saturating unstable-response counter.
    localparam int PUF_UNSTABLE_W = 16;

    // Evaluation sequencer states.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRST = 3'd1,
        S_FIRE = 3'd2,
        S_WAIT = 3'd3,
        S_SAMP = 3'd4,
        S_DONE = 3'd5
    } puf_state_e;

endpackage : puf_pkg
`default_nettype wire

// File: rtl/puf_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : puf_sync2
//  Description : Two-flop synchronizer for the racy PUF output. Both stages
//                clear to 0 on the asynchronous active-low reset.
//  Revision    : 1.0  initial release
// ============================================================================
module puf_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // First stage may go metastable; second stage gives it a full cycle to resolve.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : puf_sync2
`default_nettype wire

// File: rtl/puf_eval_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : puf_eval_ctrl
//  Description : Evaluation sequencer for the N-stage XOR arbiter PUF.
//                Accepts a challenge, runs PRST/FIRE/WAIT/SAMP per
//                evaluation, and returns one response bit per challenge.
//                Optional feature macro: PUF_MAJORITY_EN
//                  defined   -> REPS evaluations, majority vote, live
//                               unstable_cnt
//                  undefined -> single evaluation, resp_stable follows
//                               resp_valid, unstable_cnt tied to 0
//  Revision    : 1.0  initial release
// ============================================================================
module puf_eval_ctrl
    import puf_pkg::*;
#(
    parameter int N      = PUF_N_DEFAULT,
    parameter int SETTLE = 4,
    parameter int REPS   = 5
) (
    input  logic                      clk,
    input  logic                      reset_n,
    // challenge request port
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [N-1:0]              req_challenge,
    // response port
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic                      resp_bit,
    output logic                      resp_stable,
    output logic [PUF_UNSTABLE_W-1:0] unstable_cnt,
    // PUF pins
    output logic [N-1:0]              puf_sel,
    output logic                      puf_reset,
    output logic                      puf_in,
    input  logic                      puf_out
);

    // ------------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------------
`ifdef PUF_MAJORITY_EN
    localparam int EFF_REPS = REPS;
`else
    localparam int EFF_REPS = 1;
`endif
    localparam int ONES_W = $clog2(EFF_REPS + 1);
    localparam int REP_W  = (EFF_REPS > 1) ? $clog2(EFF_REPS) : 1;
    localparam int CNT_W  = $clog2(SETTLE);

    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [REP_W-1:0]  LAST_REP    = REP_W'(EFF_REPS - 1);
    localparam logic [ONES_W-1:0] HALF_REPS   = ONES_W'(EFF_REPS / 2);
    localparam logic [ONES_W-1:0] ALL_ONES    = ONES_W'(EFF_REPS);

    // ------------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------------
    generate
        if (SETTLE < 2) begin : g_bad_settle
            $error("puf_eval_ctrl: SETTLE must be >= 2");
        end
        if ((REPS < 1) || ((REPS % 2) == 0)) begin : g_bad_reps
            $error("puf_eval_ctrl: REPS must be odd and >= 1");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    puf_state_e         state_q, state_d;
    logic [N-1:0]       sel_q, sel_d;
    logic [ONES_W-1:0]  ones_q, ones_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [CNT_W-1:0]   settle_q, settle_d;
    logic               resp_valid_q, resp_valid_d;
    logic               resp_bit_q, resp_bit_d;
    logic               puf_reset_q, puf_reset_d;
    logic               puf_in_q, puf_in_d;

    logic               out_sync;
    logic [ONES_W-1:0]  ones_next;
    logic               last_rep;

    // The PUF output races against clk, so it is only ever seen through the synchronizer.
    puf_sync2 u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (puf_out),
        .q_o     (out_sync)
    );

    assign ones_next = ones_q + ONES_W'(out_sync);
    assign last_rep  = (rep_q == LAST_REP);

    // State register plus all registered outputs; async reset discards any evaluation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            sel_q        <= '0;
            ones_q       <= '0;
            rep_q        <= '0;
            settle_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_bit_q   <= 1'b0;
            puf_reset_q  <= 1'b0;
            puf_in_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            ones_q       <= ones_d;
            rep_q        <= rep_d;
            settle_q     <= settle_d;
            resp_valid_q <= resp_valid_d;
            resp_bit_q   <= resp_bit_d;
            puf_reset_q  <= puf_reset_d;
            puf_in_q     <= puf_in_d;
        end
    end

    // Next-state and datapath updates; PUF pins and resp_valid are decoded from
    // the next state so that they are registered yet line up with the state.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        ones_d     = ones_q;
        rep_d      = rep_q;
        settle_d   = settle_q;
        resp_bit_d = resp_bit_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_PRST;
                    sel_d   = req_challenge;
                    ones_d  = '0;
                    rep_d   = '0;
                end
            end
            S_PRST: begin
                state_d = S_FIRE;
            end
            S_FIRE: begin
                state_d  = S_WAIT;
                settle_d = SETTLE_LOAD;
            end
            S_WAIT: begin
                if (settle_q == '0) begin
                    state_d = S_SAMP;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            S_SAMP: begin
                ones_d = ones_next;
                rep_d  = rep_q + 1'b1;
                if (last_rep) begin
                    state_d    = S_DONE;
                    resp_bit_d = (ones_next > HALF_REPS);
                end else begin
                    state_d = S_PRST;
                end
            end
            S_DONE: begin
                // A new challenge is only accepted once back in IDLE.
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        puf_reset_d  = (state_d == S_PRST);
        puf_in_d     = (state_d == S_FIRE) || (state_d == S_WAIT) ||
                       (state_d == S_SAMP);
        resp_valid_d = (state_d == S_DONE);
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_bit   = resp_bit_q;
    assign puf_sel    = sel_q;
    assign puf_reset  = puf_reset_q;
    assign puf_in     = puf_in_q;

`ifdef PUF_MAJORITY_EN
    // ------------------------------------------------------------------------
    // Vote agreement flag and saturating unstable counter
    // ------------------------------------------------------------------------
    logic                      resp_stable_q, resp_stable_d;
    logic [PUF_UNSTABLE_W-1:0] unstable_q, unstable_d;

    // Agreement is captured with the final vote; disagreeing responses are counted on handoff.
    always_comb begin
        resp_stable_d = resp_stable_q;
        unstable_d    = unstable_q;
        if ((state_q == S_SAMP) && last_rep) begin
            resp_stable_d = (ones_next == '0) || (ones_next == ALL_ONES);
        end
        if ((state_q == S_DONE) && resp_ready && !resp_stable_q &&
            (unstable_q != '1)) begin
            unstable_d = unstable_q + 1'b1;
        end
    end

    // Agreement flag and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_stable_q <= 1'b0;
            unstable_q    <= '0;
        end else begin
            resp_stable_q <= resp_stable_d;
            unstable_q    <= unstable_d;
        end
    end

    assign resp_stable  = resp_stable_q;
    assign unstable_cnt = unstable_q;
`else
    // A single sample always agrees with itself.
    assign resp_stable  = resp_valid_q;
    assign unstable_cnt = '0;
`endif

endmodule : puf_eval_ctrl
`default_nettype wire

// File: tb/tb_puf_eval_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_puf_eval_ctrl
//  Description : Self-checking bench for puf_eval_ctrl. A behavioural PUF
//                model plays a per-challenge pattern of per-evaluation bits;
//                expected response, agreement and latency are computed from
//                that pattern. Honours PUF_MAJORITY_EN like the design.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_puf_eval_ctrl;

    localparam int N      = 128;
    localparam int SETTLE = 4;
    localparam int REPS   = 5;
`ifdef PUF_MAJORITY_EN
    localparam int EFF_REPS = REPS;
    localparam bit VOTE     = 1'b1;
`else
    localparam int EFF_REPS = 1;
    localparam bit VOTE     = 1'b0;
`endif
    localparam int LAT = EFF_REPS * (SETTLE + 3);

    logic          clk;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic [N-1:0]  req_challenge;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_bit;
    logic          resp_stable;
    logic [15:0]   unstable_cnt;
    logic [N-1:0]  puf_sel;
    logic          puf_reset;
    logic          puf_in;
    logic          puf_out = 1'b0;

    int            checks = 0;
    int            errors = 0;

    // PUF model state: pattern bit r is the answer of evaluation r of the current challenge.
    logic [31:0]   cur_pat   = '0;
    int            pat_base  = 0;
    int            prst_total = 0;
    int            unstable_model = 0;

    puf_eval_ctrl #(
        .N      (N),
        .SETTLE (SETTLE),
        .REPS   (REPS)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_challenge (req_challenge),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_bit      (resp_bit),
        .resp_stable   (resp_stable),
        .unstable_cnt  (unstable_cnt),
        .puf_sel       (puf_sel),
        .puf_reset     (puf_reset),
        .puf_in        (puf_in),
        .puf_out       (puf_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PUF model: each reset pulse starts a new evaluation whose answer is the next pattern bit.
    always @(negedge clk) begin : puf_model
        int idx;
        if (puf_reset === 1'b1) begin
            idx = prst_total - pat_base;
            puf_out    <= (idx >= 0 && idx < 32) ? cur_pat[idx] : 1'b0;
            prst_total <= prst_total + 1;
        end
    end

    task automatic test_reset();
        reset_n       = 1'b0;
        req_valid     = 1'b0;
        req_challenge = '0;
        resp_ready    = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        unstable_model = 0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        checks++; if (resp_bit !== 1'b0) begin errors++; $display("FAIL reset_resp_bit: got %b want 0", resp_bit); end
        checks++; if (resp_stable !== 1'b0) begin errors++; $display("FAIL reset_resp_stable: got %b want 0", resp_stable); end
        checks++; if (unstable_cnt !== 16'h0) begin errors++; $display("FAIL reset_unstable_cnt: got %0h want 0", unstable_cnt); end
        checks++; if (puf_sel !== '0) begin errors++; $display("FAIL reset_puf_sel: got %0h want 0", puf_sel); end
        checks++; if (puf_reset !== 1'b0) begin errors++; $display("FAIL reset_puf_reset: got %b want 0", puf_reset); end
        checks++; if (puf_in !== 1'b0) begin errors++; $display("FAIL reset_puf_in: got %b want 0", puf_in); end
    endtask

    // One complete transaction: request, evaluation monitoring, back-pressure, handoff.
    task automatic run_req(input logic [N-1:0] ch, input logic [31:0] pat, input int gap);
        int ones;
        bit exp_bit;
        bit exp_stable;
        int cyc;
        int prst_seen;
        bit got;
        bit sel_ok;
        bit pin_ok;
        bit hold_ok;

        ones = 0;
        for (int r = 0; r < EFF_REPS; r++) ones += int'(pat[r]);
        exp_bit    = (2 * ones > EFF_REPS);
        exp_stable = (ones == 0) || (ones == EFF_REPS);

        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL req_ready_before: got %b want 1", req_ready); end
        cur_pat       = pat;
        pat_base      = prst_total;
        req_valid     = 1'b1;
        req_challenge = ch;
        @(posedge clk);
        #1;
        req_valid     = 1'b0;
        req_challenge = ~ch;

        cyc = 0; prst_seen = 0; got = 1'b0; sel_ok = 1'b1; pin_ok = 1'b1;
        while (!got && cyc < LAT + 20) begin
            @(negedge clk);
            cyc++;
            if (puf_reset === 1'b1) begin
                prst_seen++;
                if (puf_in !== 1'b0) pin_ok = 1'b0;
            end
            if (puf_sel !== ch) sel_ok = 1'b0;
            if (resp_valid === 1'b1) got = 1'b1;
        end
        checks++; if (!got) begin errors++; $display("FAIL resp_timeout: no resp_valid within %0d cycles", LAT + 20); return; end
        checks++; if (cyc - 1 != LAT) begin errors++; $display("FAIL latency: got %0d want %0d", cyc - 1, LAT); end
        checks++; if (prst_seen != EFF_REPS) begin errors++; $display("FAIL prst_pulses: got %0d want %0d", prst_seen, EFF_REPS); end
        checks++; if (!sel_ok) begin errors++; $display("FAIL puf_sel_hold: got %0h want %0h", puf_sel, ch); end
        checks++; if (!pin_ok) begin errors++; $display("FAIL puf_in_in_prst: got 1 want 0"); end
        checks++; if (resp_bit !== exp_bit) begin errors++; $display("FAIL resp_bit: got %b want %b (pat %0h)", resp_bit, exp_bit, pat); end
        checks++; if (resp_stable !== exp_stable) begin errors++; $display("FAIL resp_stable: got %b want %b (pat %0h)", resp_stable, exp_stable, pat); end
        checks++; if (unstable_cnt !== 16'(unstable_model)) begin errors++; $display("FAIL unstable_before: got %0d want %0d", unstable_cnt, unstable_model); end

        hold_ok = 1'b1;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_bit !== exp_bit || req_ready !== 1'b0 || puf_sel !== ch)
                hold_ok = 1'b0;
        end
        if (gap > 0) begin
            checks++; if (!hold_ok) begin errors++; $display("FAIL backpressure_hold: got v=%b b=%b rr=%b want v=1 b=%b rr=0", resp_valid, resp_bit, req_ready, exp_bit); end
        end

        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        if (VOTE && !exp_stable && unstable_model < 16'hFFFF) unstable_model++;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL req_ready_after: got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL resp_valid_after: got %b want 0", resp_valid); end
        checks++; if (unstable_cnt !== 16'(unstable_model)) begin errors++; $display("FAIL unstable_after: got %0d want %0d", unstable_cnt, unstable_model); end
    endtask

    task automatic test_single();
        run_req('0, 32'hFFFF_FFFF, 0);
    endtask

    task automatic test_unstable();
        logic [N-1:0] ch;
        ch = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_req(ch, 32'b01101, 0);
    endtask

    task automatic test_backpressure();
        logic [N-1:0] ch;
        ch = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_req(ch, 32'b10010, 20);
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] ch;
        bit seen;
        ch = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(negedge clk);
        cur_pat       = 32'hFFFF_FFFF;
        pat_base      = prst_total;
        req_valid     = 1'b1;
        req_challenge = ch;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        // PRST, FIRE, WAIT1, WAIT2, WAIT3
        repeat (5) @(negedge clk);
        checks++; if (puf_in !== 1'b1) begin errors++; $display("FAIL mid_eval_puf_in: got %b want 1", puf_in); end
        reset_n = 1'b0;
        #1;
        unstable_model = 0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_req_ready: got %b want 1", req_ready); end
        checks++; if (puf_in !== 1'b0) begin errors++; $display("FAIL mid_reset_puf_in: got %b want 0", puf_in); end
        checks++; if (puf_sel !== '0) begin errors++; $display("FAIL mid_reset_puf_sel: got %0h want 0", puf_sel); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_resp_valid: got %b want 0", resp_valid); end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < LAT + 5; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || puf_reset !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL mid_reset_activity: got activity after reset want none"); end
        run_req(ch, 32'h0, 0);
    endtask

    task automatic test_random();
        logic [N-1:0] ch;
        logic [31:0]  pat;
        int           gap;
        for (int i = 0; i < 100; i++) begin
            ch  = {$urandom(), $urandom(), $urandom(), $urandom()};
            pat = $urandom();
            gap = int'($urandom_range(0, 4));
            run_req(ch, pat, gap);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        test_reset();
        test_single();
        test_unstable();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_puf_eval_ctrl
`default_nettype wire
